// File: rtl/rr_resource_arbiter.sv
// ---------------------------------------------------------------------------
// rr_resource_arbiter
//
// Round-robin arbiter sharing one resource among N requesters. A grant is
// held until its owner drops its request. The next owner is then chosen in
// rotating order starting just after the previous owner, so no requester
// starves. All outputs are registered.
//
// Optional feature (compile-time macro RR_ARB_HOLD_LIMIT_EN):
//   limits one owner to MAX_HOLD consecutive cycles. It then force-releases
//   the owner and pulses hold_expired for one cycle. Without the macro no
//   counter is built and hold_expired is tied to 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req[N]       in   request vector, bit i = requester i wants/keeps resource
//   grant[N]     out  registered one-hot grant, zero when idle
//   grant_id     out  binary index of current owner, 0 when idle
//   grant_valid  out  high while any grant bit is set
//   hold_expired out  one-cycle pulse when the hold limit revokes a grant
//
// Handshake: a requester raises req[i] and keeps it high while it needs the
// resource. grant[i] is the acknowledge and stays high as long as req[i] is
// high. The owner releases by dropping req[i]. The edge that samples
// req[i]=0 hands the grant to the next pending requester in the same cycle,
// or returns the arbiter to idle if nothing else is pending.
// ---------------------------------------------------------------------------
module rr_resource_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           hold_expired
);

    if (IDW != $clog2(N) || N < 2 || N > 16 || MAX_HOLD < 1) begin : g_param_check
        $error("rr_resource_arbiter: bad parameters (need 2<=N<=16, IDW=clog2(N), MAX_HOLD>=1)");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           grant_valid_q, grant_valid_d;

    logic [IDW:0]   pick;       // {found, index}
    logic [IDW-1:0] next_ptr;
    logic           own_req;
    logic           force_rel;

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_expired_q, hold_expired_d;
`endif

    // First set bit of mask, searching start, start+1, ... wrapping modulo N.
    // Iterating from the farthest offset down lets the nearest hit win.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] mask,
                                             input logic [IDW-1:0] start);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % N;
            if (mask[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
        hold_cnt_d     = hold_cnt_q;
        hold_expired_d = 1'b0;
`endif

        own_req  = req[grant_id_q];
        next_ptr = IDW'((int'(grant_id_q) + 1) % N);
`ifdef RR_ARB_HOLD_LIMIT_EN
        force_rel = own_req && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`else
        force_rel = 1'b0;
`endif

        // In BUSY the current owner is masked out so a forced release never
        // re-picks it while someone else is waiting.
        if (state_q == IDLE) pick = rr_pick(req, ptr_q);
        else                 pick = rr_pick(req & ~grant_q, next_ptr);

        case (state_q)
            IDLE: begin
                if (pick[IDW]) begin
                    state_d       = BUSY;
                    grant_d       = N'(1) << pick[IDW-1:0];
                    grant_id_d    = pick[IDW-1:0];
                    grant_valid_d = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
                    hold_cnt_d    = '0;
`endif
                end
            end
            BUSY: begin
                if (!own_req || force_rel) begin
                    ptr_d = next_ptr;
`ifdef RR_ARB_HOLD_LIMIT_EN
                    hold_expired_d = force_rel;
                    hold_cnt_d     = '0;
`endif
                    if (pick[IDW]) begin
                        grant_d    = N'(1) << pick[IDW-1:0];
                        grant_id_d = pick[IDW-1:0];
                    end else if (!force_rel) begin
                        state_d       = IDLE;
                        grant_d       = '0;
                        grant_id_d    = '0;
                        grant_valid_d = 1'b0;
                    end
                    // Forced release with nobody else waiting: owner keeps
                    // the grant and its hold counter restarts.
                end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
                    hold_cnt_d = hold_cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_cnt_q     <= '0;
            hold_expired_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_cnt_q     <= hold_cnt_d;
            hold_expired_q <= hold_expired_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
    assign hold_expired = hold_expired_q;
`else
    assign hold_expired = 1'b0;
`endif

endmodule

// File: tb/tb_rr_resource_arbiter.sv
module tb_rr_resource_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 8;
    localparam int W        = N + IDW + 2;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           hold_expired;

    always #5 clk = ~clk;

    rr_resource_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .hold_expired(hold_expired)
    );

    // ---------------- scoreboard ----------------
    int             checks   = 0;
    int             failures = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   got;
    logic [W-1:0]   want;

    // Expected output word {grant, grant_id, grant_valid, hold_expired}.
    function automatic logic [W-1:0] pack_exp(input logic [N-1:0] g, input logic e);
        logic [IDW-1:0] id;
        id = '0;
        for (int i = 0; i < N; i++) if (g[i]) id = IDW'(i);
        return {g, id, |g, e};
    endfunction

    // ---------------- driver ----------------
    // Pushes the output expected after the next edge, applies req, then
    // advances to 1ns after that edge where the caller samples.
    task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] g, input logic e);
        exp_q.push_back(pack_exp(g, e));
        req = r;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req   = 4'b1111;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(pack_exp(4'b0000, 1'b0));
        got  = {grant, grant_id, grant_valid, hold_expired};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_hold got=%b expected=%b", got, want);
        end
        rst_n = 1'b1;
        drive_cycle(4'b1111, 4'b0001, 1'b0);
        got  = {grant, grant_id, grant_valid, hold_expired};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_release got=%b expected=%b", got, want);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] stim [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        logic [N-1:0] expg [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(stim[i], expg[i], 1'b0);
            got  = {grant, grant_id, grant_valid, hold_expired};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL rotation[%0d] got=%b expected=%b", i, got, want);
            end
        end
    endtask

    task automatic test_hold_wrap();
        logic [N-1:0] stim [8] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                   4'b1000, 4'b1001, 4'b0001};
        logic [N-1:0] expg [8] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                   4'b1000, 4'b1000, 4'b0001};
        for (int i = 0; i < 8; i++) begin
            drive_cycle(stim[i], expg[i], 1'b0);
            got  = {grant, grant_id, grant_valid, hold_expired};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL hold_wrap[%0d] got=%b expected=%b", i, got, want);
            end
        end
    endtask

    task automatic test_idle_return();
        logic [N-1:0] stim [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                                   4'b0101, 4'b0000};
        logic [N-1:0] expg [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                                   4'b0001, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            drive_cycle(stim[i], expg[i], 1'b0);
            got  = {grant, grant_id, grant_valid, hold_expired};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL idle_return[%0d] got=%b expected=%b", i, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] expg [6] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive_cycle(4'b0010, expg[i], 1'b0);
                1: begin
                    // Between edges: reset must clear outputs without a clock.
                    #2 rst_n = 1'b0;
                    #1 exp_q.push_back(pack_exp(expg[i], 1'b0));
                end
                2: begin
                    req = 4'b1111;
                    @(posedge clk);
                    #1 exp_q.push_back(pack_exp(expg[i], 1'b0));
                    rst_n = 1'b1;
                end
                3: drive_cycle(4'b0110, expg[i], 1'b0);
                4: drive_cycle(4'b0100, expg[i], 1'b0);
                default: drive_cycle(4'b0000, expg[i], 1'b0);
            endcase
            got  = {grant, grant_id, grant_valid, hold_expired};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL async_reset[%0d] got=%b expected=%b", i, got, want);
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [N-1:0] g;
        logic         e;
        for (int i = 0; i < 12; i++) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
            g = (i < MAX_HOLD) ? 4'b0001 : 4'b0010;
            e = (i == MAX_HOLD);
`else
            g = 4'b0001;
            e = 1'b0;
`endif
            drive_cycle(4'b0011, g, e);
            got  = {grant, grant_id, grant_valid, hold_expired};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL hold_limit[%0d] got=%b expected=%b", i, got, want);
            end
        end
    endtask

    // Random requests against a behavioural reference of the arbiter.
    task automatic test_random();
        logic         m_busy;
        int           m_ptr, m_owner, m_cnt, win, idx;
        logic         m_force;
        logic [N-1:0] r, mask;
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            r = N'($urandom_range(0, 15));
            if (m_busy && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            m_force = 1'b0;
            if (!m_busy) begin
                win = -1;
                for (int o = N - 1; o >= 0; o--) begin
                    idx = (m_ptr + o) % N;
                    if (r[idx]) win = idx;
                end
                if (win >= 0) begin
                    m_busy = 1'b1; m_owner = win; m_cnt = 0;
                end
            end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
                m_force = r[m_owner] && (m_cnt == MAX_HOLD - 1);
`endif
                if (!r[m_owner] || m_force) begin
                    m_ptr = (m_owner + 1) % N;
                    mask  = r;
                    mask[m_owner] = 1'b0;
                    win = -1;
                    for (int o = N - 1; o >= 0; o--) begin
                        idx = (m_ptr + o) % N;
                        if (mask[idx]) win = idx;
                    end
                    m_cnt = 0;
                    if (win >= 0) m_owner = win;
                    else if (!m_force) m_busy = 1'b0;
                end else begin
                    m_cnt++;
                end
            end
            drive_cycle(r, m_busy ? N'(1) << m_owner : '0, m_force);
            got  = {grant, grant_id, grant_valid, hold_expired};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL random[%0d] req=%b got=%b expected=%b", c, r, got, want);
            end
        end
        req = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b1;
        req   = '0;
        #1 rst_n = 1'b0;
        test_reset();
        test_rotation();
        test_hold_wrap();
        test_idle_return();
        test_async_reset();
        test_hold_limit();
        test_random();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
